// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter that shares one non-pipelined FloatAdder between NUM_REQ requesters.
// Optional build macro FPADD_ARB_ZERO_BYPASS_EN answers additions with a zero operand without using the adder.
module fp_adder_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WAIT_MAX = 255
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     ReqValid,
  input  logic [NUM_REQ*32-1:0]  ReqOp1,
  input  logic [NUM_REQ*32-1:0]  ReqOp2,
  output logic [NUM_REQ-1:0]     ReqReady,
  output logic [NUM_REQ-1:0]     RspValid,
  output logic [31:0]            RspResult,
  output logic                   RspError,
  output logic                   Busy,
  output logic [31:0]            AdderOp1,
  output logic [31:0]            AdderOp2,
  output logic                   AdderInputValid,
  input  logic [31:0]            AdderResult,
  input  logic                   AdderResultValid
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_State, w_NextState;
  logic [IDX_W-1:0] r_LastGrant, r_Owner, w_GrantIdx, w_Idx;
  logic             w_GrantFound, w_Hs, w_Bypass;
  logic [7:0]       r_WaitCnt;
  logic [31:0]      r_AdderOp1, r_AdderOp2, r_Result, w_SelOp1, w_SelOp2, w_BypassRes;
  logic             r_Error;

  // Scan downward so the candidate nearest LastGrant+1 wins.
  always_comb begin
    w_GrantFound = 1'b0;
    w_GrantIdx   = '0;
    w_Idx        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_Idx = IDX_W'((int'(r_LastGrant) + 1 + k) % NUM_REQ);
      if (ReqValid[w_Idx]) begin
        w_GrantFound = 1'b1;
        w_GrantIdx   = w_Idx;
      end
    end
  end

  assign w_Hs     = (r_State == S_IDLE) && w_GrantFound;
  assign w_SelOp1 = ReqOp1[int'(w_GrantIdx)*32 +: 32];
  assign w_SelOp2 = ReqOp2[int'(w_GrantIdx)*32 +: 32];

`ifdef FPADD_ARB_ZERO_BYPASS_EN
  logic w_Op1Zero, w_Op2Zero;
  assign w_Op1Zero = (w_SelOp1[30:0] == 31'd0);
  assign w_Op2Zero = (w_SelOp2[30:0] == 31'd0);
  assign w_Bypass  = w_Op1Zero || w_Op2Zero;
  always_comb begin
    w_BypassRes = w_SelOp1;
    if (w_Op1Zero && w_Op2Zero) w_BypassRes = {w_SelOp1[31] & w_SelOp2[31], 31'd0};
    else if (w_Op1Zero)         w_BypassRes = w_SelOp2;
  end
`else
  assign w_Bypass    = 1'b0;
  assign w_BypassRes = 32'd0;
`endif

  always_comb begin
    w_NextState = r_State;
    case (r_State)
      S_IDLE:  if (w_Hs) w_NextState = w_Bypass ? S_RESP : S_ISSUE;
      S_ISSUE: w_NextState = S_WAIT;
      S_WAIT:  if (AdderResultValid || (r_WaitCnt == WAIT_LIM)) w_NextState = S_RESP;
      S_RESP:  w_NextState = S_IDLE;
      default: w_NextState = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_State     <= S_IDLE;
      r_LastGrant <= IDX_W'(NUM_REQ - 1);
      r_Owner     <= '0;
      r_WaitCnt   <= '0;
      r_AdderOp1  <= '0;
      r_AdderOp2  <= '0;
      r_Result    <= '0;
      r_Error     <= 1'b0;
    end else begin
      r_State <= w_NextState;
      case (r_State)
        S_IDLE: if (w_Hs) begin
          r_AdderOp1  <= w_SelOp1;
          r_AdderOp2  <= w_SelOp2;
          r_Owner     <= w_GrantIdx;
          r_LastGrant <= w_GrantIdx;
          if (w_Bypass) begin
            r_Result <= w_BypassRes;
            r_Error  <= 1'b0;
          end
        end
        S_ISSUE: r_WaitCnt <= '0;
        S_WAIT: begin
          if (AdderResultValid) begin
            r_Result <= AdderResult;
            r_Error  <= 1'b0;
          end else if (r_WaitCnt == WAIT_LIM) begin
            r_Result <= '0;
            r_Error  <= 1'b1;
          end else begin
            r_WaitCnt <= r_WaitCnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ReqReady = '0;
    RspValid = '0;
    if (w_Hs) ReqReady[w_GrantIdx] = 1'b1;
    if (r_State == S_RESP) RspValid[r_Owner] = 1'b1;
  end

  assign RspResult       = r_Result;
  assign RspError        = r_Error;
  assign Busy            = (r_State != S_IDLE);
  assign AdderOp1        = r_AdderOp1;
  assign AdderOp2        = r_AdderOp2;
  assign AdderInputValid = (r_State == S_ISSUE);

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Scoreboard bench for fp_adder_arbiter with a table-driven model adder of fixed latency.
module tb_fp_adder_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int WAIT_MAX = 255;
  localparam int LAT      = 2;

  logic                  Clock, Reset;
  logic [NUM_REQ-1:0]    ReqValid, ReqReady, RspValid;
  logic [NUM_REQ*32-1:0] ReqOp1, ReqOp2;
  logic [31:0]           RspResult, AdderOp1, AdderOp2, AdderResult;
  logic                  RspError, Busy, AdderInputValid, AdderResultValid;

  fp_adder_arbiter #(.NUM_REQ(NUM_REQ), .WAIT_MAX(WAIT_MAX)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqOp1(ReqOp1), .ReqOp2(ReqOp2),
    .ReqReady(ReqReady), .RspValid(RspValid), .RspResult(RspResult), .RspError(RspError),
    .Busy(Busy), .AdderOp1(AdderOp1), .AdderOp2(AdderOp2), .AdderInputValid(AdderInputValid),
    .AdderResult(AdderResult), .AdderResultValid(AdderResultValid));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct { int owner; logic [31:0] res; logic err; } exp_t;
  exp_t sb[$];
  int checks, failures;
  int cyc, iv_cnt, hs_cnt, rsp_cnt, iv_cyc, hs_cyc, rsp_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Hand-computed IEEE-754 single sums for every operand pair the bench issues.
  function automatic logic [31:0] fadd_tbl(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2=3
      {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1=2
      {32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2=4
      {32'h40400000, 32'h3F800000}: return 32'h40800000; // 3+1=4
      {32'h40800000, 32'h40000000}: return 32'h40C00000; // 4+2=6
      {32'h00000000, 32'h40400000}: return 32'h40400000; // 0+3=3
      {32'h80000000, 32'h80000000}: return 32'h80000000; // -0+-0=-0
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  // Model adder: answers LAT cycles after the start pulse unless hung; clears on Reset.
  logic m_hang, m_rv, stray, m_pend;
  logic [31:0] m_res, m_a, m_b;
  int m_cnt;
  assign AdderResultValid = m_rv | stray;
  assign AdderResult      = m_res;
  initial begin
    m_rv = 0; m_res = 0; m_pend = 0; m_cnt = 0; m_a = 0; m_b = 0;
    forever begin
      @(negedge Clock);
      m_rv = 1'b0;
      if (Reset) m_pend = 1'b0;
      else begin
        if (m_pend) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_pend = 1'b0;
            if (!m_hang) begin m_rv = 1'b1; m_res = fadd_tbl(m_a, m_b); end
          end
        end
        if (AdderInputValid) begin m_pend = 1'b1; m_cnt = LAT; m_a = AdderOp1; m_b = AdderOp2; end
      end
    end
  end

  // Monitor: pops the scoreboard on every response strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      cyc++;
      if (!Reset) begin
        if (AdderInputValid) begin iv_cnt++; iv_cyc = cyc; end
        if (|(ReqValid & ReqReady)) begin hs_cnt++; hs_cyc = cyc; end
        if (|RspValid) begin
          rsp_cnt++; rsp_cyc = cyc;
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp actual RspValid=%b RspResult=%h required no response", RspValid, RspResult);
          end else begin
            e = sb.pop_front();
            chk("rsp_owner", 32'(RspValid), 32'(4'b0001 << e.owner));
            chk("rsp_result", RspResult, e.res);
            chk("rsp_error", 32'(RspError), 32'(e.err));
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; ReqValid = '0; stray = 1'b0;
    tick(2);
    Reset = 1'b0;
  endtask

  task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b);
    ReqOp1[r*32 +: 32] = a;
    ReqOp2[r*32 +: 32] = b;
  endtask

  task automatic push(input int owner, input logic [31:0] res, input logic err);
    exp_t e;
    e.owner = owner; e.res = res; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_cnt < target && n < budget) begin tick(1); n++; end
    chk("hs_timeout", 32'(hs_cnt >= target), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin tick(1); n++; end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int iv0, hs0, rsp0;
    Reset = 1'b1; ReqValid = '0; ReqOp1 = '0; ReqOp2 = '0; m_hang = 1'b0; stray = 1'b0;
    tick(2);
    Reset = 1'b0;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ready", 32'(ReqReady), 32'd0);
    chk("rst_rspvalid", 32'(RspValid), 32'd0);
    chk("rst_ivalid", 32'(AdderInputValid), 32'd0);
    chk("rst_op1", AdderOp1, 32'd0);
    chk("rst_op2", AdderOp2, 32'd0);
    chk("rst_result", RspResult, 32'd0);
    chk("rst_error", 32'(RspError), 32'd0);

    // 1: single request 1.0 + 2.0
    set_ops(0, 32'h3F800000, 32'h40000000);
    push(0, 32'h40400000, 1'b0);
    iv0 = iv_cnt; hs0 = hs_cnt;
    ReqValid = 4'b0001;
    #1 chk("t1_ready", 32'(ReqReady), 32'h1);
    wait_hs(hs0 + 1, 20);
    ReqValid = '0;
    set_ops(0, 32'h12345678, 32'h9ABCDEF0);
    #1;
    chk("t1_op1_held", AdderOp1, 32'h3F800000);
    chk("t1_op2_held", AdderOp2, 32'h40000000);
    wait_drain(50);
    chk("t1_ivalid_pulses", 32'(iv_cnt - iv0), 32'd1);

    // 2: all requesters held from reset, rotation 0,1,2,3,0
    do_reset();
    set_ops(0, 32'h3F800000, 32'h3F800000);
    set_ops(1, 32'h40000000, 32'h40000000);
    set_ops(2, 32'h40400000, 32'h3F800000);
    set_ops(3, 32'h40800000, 32'h40000000);
    push(0, 32'h40000000, 1'b0);
    push(1, 32'h40800000, 1'b0);
    push(2, 32'h40800000, 1'b0);
    push(3, 32'h40C00000, 1'b0);
    push(0, 32'h40000000, 1'b0);
    hs0 = hs_cnt;
    ReqValid = 4'b1111;
    wait_hs(hs0 + 5, 100);
    ReqValid = '0;
    wait_drain(50);

    // 3: adder never answers -> timeout after WAIT_MAX+1 WAIT cycles
    m_hang = 1'b1;
    set_ops(1, 32'h3F800000, 32'h40000000);
    push(1, 32'h00000000, 1'b1);
    hs0 = hs_cnt;
    ReqValid = 4'b0010;
    wait_hs(hs0 + 1, 20);
    ReqValid = '0;
    wait_drain(WAIT_MAX + 50);
    chk("t3_timeout_cycles", 32'(rsp_cyc - iv_cyc), 32'(WAIT_MAX + 2));
    m_hang = 1'b0;
    set_ops(3, 32'h3F800000, 32'h3F800000);
    push(3, 32'h40000000, 1'b0);
    hs0 = hs_cnt;
    ReqValid = 4'b1000;
    wait_hs(hs0 + 1, 20);
    ReqValid = '0;
    wait_drain(50);

    // 4: reset during WAIT aborts; next grant restarts at req0
    m_hang = 1'b1;
    set_ops(2, 32'h40000000, 32'h40000000);
    hs0 = hs_cnt; rsp0 = rsp_cnt;
    ReqValid = 4'b0100;
    wait_hs(hs0 + 1, 20);
    ReqValid = '0;
    tick(5);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("t4_busy_after_reset", 32'(Busy), 32'd0);
    m_hang = 1'b0;
    tick(3);
    chk("t4_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
    set_ops(0, 32'h40400000, 32'h3F800000);
    push(0, 32'h40800000, 1'b0);
    hs0 = hs_cnt;
    ReqValid = 4'b1111;
    #1 chk("t4_ready_req0", 32'(ReqReady), 32'h1);
    wait_hs(hs0 + 1, 20);
    ReqValid = '0;
    wait_drain(50);

    // 5: stray AdderResultValid while idle
    rsp0 = rsp_cnt;
    stray = 1'b1;
    tick(1);
    stray = 1'b0;
    tick(3);
    chk("t5_busy", 32'(Busy), 32'd0);
    chk("t5_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);

    // 6: 0.0 + 3.0 from req2; 7: -0 + -0 from req1
    set_ops(2, 32'h00000000, 32'h40400000);
    push(2, 32'h40400000, 1'b0);
    iv0 = iv_cnt; hs0 = hs_cnt;
    ReqValid = 4'b0100;
    wait_hs(hs0 + 1, 20);
    ReqValid = '0;
    wait_drain(50);
`ifdef FPADD_ARB_ZERO_BYPASS_EN
    chk("t6_ivalid_pulses", 32'(iv_cnt - iv0), 32'd0);
    chk("t6_bypass_latency", 32'(rsp_cyc - hs_cyc), 32'd1);
`else
    chk("t6_ivalid_pulses", 32'(iv_cnt - iv0), 32'd1);
`endif
    set_ops(1, 32'h80000000, 32'h80000000);
    push(1, 32'h80000000, 1'b0);
    hs0 = hs_cnt;
    ReqValid = 4'b0010;
    wait_hs(hs0 + 1, 20);
    ReqValid = '0;
    wait_drain(50);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
